count_up_down_mod: RTL and testbench
====================================

// Module: count_up_down_mod
// PURPOSE
//  Parametrised modulo up/down counter with synchronous load, enable prescaler and terminal-count pulse.
//  Generalises the 4-bit up/down counter in width, modulus and tick rate.
//  Used as the general timing/event counter feeding downstream control FSMs.
// PARAMETERS
//  WIDTH     4             counter width in bits (>=2)
//  MAX       2**WIDTH-1    modulus top; count range 0..MAX (MAX <= 2**WIDTH-1)
//  PRESCALE  1             enabled clk cycles per count tick (>=1; 1 = every enabled cycle)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      async reset, active-high
//  enable       in   1      count enable; prescaler and counter hold when low
//  countUpDown  in   1      direction: 1 = up, 0 = down
//  load         in   1      sync load strobe
//  load_val     in   WIDTH  load value
//  sat          in   1      saturate mode select (present only with CNT_UPDN_SAT_EN)
//  count        out  WIDTH  current count, registered
//  tc           out  1      terminal-count pulse, registered, 1 cycle
//  at_max       out  1      count == MAX (decode of count register)
//  at_zero      out  1      count == 0   (decode of count register)
// BEHAVIOUR
//  - Reset (async, any time): count=0, tc=0, prescaler=0; at_zero=1, at_max=0. Outputs valid the cycle rst drops.
//  - Priority per edge: rst > load > enable tick.
//  - load=1: count <= min(load_val, MAX); prescaler cleared; tc=0; enable/direction ignored that cycle.
//  - Prescaler: pcnt increments on each enable=1 cycle; tick when pcnt==PRESCALE-1 and enable=1, then pcnt<=0.
//    enable=0 freezes pcnt (no clear). PRESCALE=1: tick = enable.
//  - On tick, up: count==MAX -> 0, tc=1; else count+1.
//  - On tick, down: count==0 -> MAX, tc=1; else count-1.
//  - tc high exactly for the cycle after the wrapping edge (same cycle count shows wrapped value); else 0.
//  - Direction sampled at the tick edge; a change takes effect on the next tick, no extra latency.
//  - Latency: count updates on the edge where tick=1; outputs registered, no comb path from inputs to count/tc.
//  - Arithmetic modulo MAX+1, never 2**WIDTH unless MAX=2**WIDTH-1; states > MAX unreachable.
//  - Load arriving on a tick edge wins; the tick is discarded.
// CONFIGURATION
//  CNT_UPDN_SAT_EN defined: port sat exists. sat=1: up at MAX holds MAX, down at 0 holds 0;
//   tc=1 for one cycle on each tick that tries to pass the limit. sat=0: wrap as above.
//  CNT_UPDN_SAT_EN undefined: no sat port; always wrap mode.
// STRUCTURE
//  Package cnt_updn_pkg: CNT_DIR_UP=1'b1, CNT_DIR_DN=1'b0 constants; clog2 helper for prescaler width.
//  Sub-module cnt_prescaler (clk, rst, enable, clear -> tick), width $clog2(PRESCALE), tied off when PRESCALE=1.
//  Top: count register, next-state mux (load/up/down/wrap/sat), tc register, at_max/at_zero decodes.
// TESTING
//  1. WIDTH=4,MAX=15,PRESCALE=1: rst, enable=1, up 17 cycles -> 0..15,0,1; tc=1 only with count=0 after 15.
//  2. MAX=9: down from reset -> 9,8,...,0,9; tc=1 with count=9 on each wrap; at_zero=1 when count=0.
//  3. PRESCALE=3, up: count advances every 3rd enabled cycle; drop enable 2 cycles mid-period -> pcnt held, period resumes.
//  4. MAX=9: load=1, load_val=12 -> count=9; load=1 with enable on a tick edge, load_val=5 -> count=5, no tick.
//  5. Assert rst mid-count (count=7, mid-prescale) between edges -> count=0, tc=0 immediately; resume from 0.
//  6. CNT_UPDN_SAT_EN, sat=1, MAX=15: up past 15 -> holds 15, tc pulses each blocked tick; down at 0 holds 0.

Source files
------------

// File: rtl/cnt_updn_pkg.sv
// cnt_updn_pkg: shared constants and helpers for the up/down counter
//   CNT_DIR_UP / CNT_DIR_DN : values of countUpDown for each direction
//   clog2                   : ceil(log2(v)), sizes the prescaler counter
package cnt_updn_pkg;

    localparam logic CNT_DIR_UP = 1'b1;
    localparam logic CNT_DIR_DN = 1'b0;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: divides enabled cycles into count ticks
//   clk    in  : clock, rising edge
//   rst    in  : async reset, active-high, clears the phase counter
//   enable in  : advances the phase counter; low freezes it
//   clear  in  : sync clear of the phase counter (used by load)
//   tick   out : high on the enabled cycle that completes a PRESCALE period
module cnt_prescaler
    import cnt_updn_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    // A one-bit floor keeps the declaration legal for PRESCALE=1, where the
    // register is held at zero and tick collapses to enable.
    localparam int PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    always_comb begin
        tick   = enable && (pcnt_q == LAST);
        pcnt_d = (PRESCALE == 1 || clear || tick) ? '0 : enable ? pcnt_q + PW'(1) : pcnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcnt_q <= '0;
        else     pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/count_up_down_mod.sv
// count_up_down_mod: modulo up/down counter with load, prescaler and terminal-count pulse
//   clk, rst (async, active-high), enable, countUpDown (1=up), load, load_val[WIDTH]
//   sat (only when CNT_UPDN_SAT_EN is defined: 1 = saturate at the limits instead of wrapping)
//   count[WIDTH] registered count, tc registered 1-cycle terminal-count pulse,
//   at_max / at_zero decodes of the count register
module count_up_down_mod
    import cnt_updn_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             countUpDown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef CNT_UPDN_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d, step_v, wrap_v, ld_v;
    logic             tc_q, tc_d, tick, up, lim, sat_on;

`ifdef CNT_UPDN_SAT_EN
    assign sat_on = sat;
`else
    assign sat_on = 1'b0;
`endif

    // Load clears the phase so the next period starts fresh after a load.
    cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (load),
        .tick   (tick)
    );

    always_comb begin
        at_max  = count_q == MAX_W;
        at_zero = count_q == '0;
        up      = countUpDown == CNT_DIR_UP;
        lim     = up ? at_max : at_zero;
        step_v  = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        wrap_v  = up ? '0 : MAX_W;
        ld_v    = (load_val > MAX_W) ? MAX_W : load_val;
        // A tick at the limit wraps (or holds when saturating) and always raises tc.
        count_d = load ? ld_v : !tick ? count_q : !lim ? step_v : sat_on ? count_q : wrap_v;
        tc_d    = !load && tick && lim;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_count_up_down_mod.sv
// tb_count_up_down_mod: checks two counter configurations against an arithmetic reference
module tb_count_up_down_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       countUpDown = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
`ifdef CNT_UPDN_SAT_EN
    logic       sat = 1'b0;
`endif

    logic [3:0] cnt0, cnt1;
    logic       tc0, tc1, am0, am1, az0, az1;

    int checks = 0;
    int failures = 0;

    int mc[2];
    int mp[2];
    int mtc[2];
    int MX[2] = '{15, 9};
    int PS[2] = '{1, 3};

    always #5 clk = ~clk;

    count_up_down_mod #(.WIDTH(4), .MAX(15), .PRESCALE(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .countUpDown(countUpDown),
        .load(load), .load_val(load_val),
`ifdef CNT_UPDN_SAT_EN
        .sat(sat),
`endif
        .count(cnt0), .tc(tc0), .at_max(am0), .at_zero(az0)
    );

    count_up_down_mod #(.WIDTH(4), .MAX(9), .PRESCALE(3)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .countUpDown(countUpDown),
        .load(load), .load_val(load_val),
`ifdef CNT_UPDN_SAT_EN
        .sat(sat),
`endif
        .count(cnt1), .tc(tc1), .at_max(am1), .at_zero(az1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count0"}, int'(cnt0), mc[0]);
        chk({tag, ".tc0"}, int'(tc0), mtc[0]);
        chk({tag, ".at_max0"}, int'(am0), (mc[0] == MX[0]) ? 1 : 0);
        chk({tag, ".at_zero0"}, int'(az0), (mc[0] == 0) ? 1 : 0);
        chk({tag, ".count1"}, int'(cnt1), mc[1]);
        chk({tag, ".tc1"}, int'(tc1), mtc[1]);
        chk({tag, ".at_max1"}, int'(am1), (mc[1] == MX[1]) ? 1 : 0);
        chk({tag, ".at_zero1"}, int'(az1), (mc[1] == 0) ? 1 : 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0;
            mp[i] = 0;
            mtc[i] = 0;
        end
    endtask

    // Reference: count modulo MX+1, one tick per PS enabled cycles.
    task automatic model_edge();
        bit hold;
`ifdef CNT_UPDN_SAT_EN
        hold = sat;
`else
        hold = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            if (load) begin
                mc[i] = (int'(load_val) > MX[i]) ? MX[i] : int'(load_val);
                mp[i] = 0;
                mtc[i] = 0;
            end else if (enable) begin
                mp[i]++;
                mtc[i] = 0;
                if (mp[i] == PS[i]) begin
                    bit lim;
                    mp[i] = 0;
                    lim = countUpDown ? (mc[i] == MX[i]) : (mc[i] == 0);
                    mtc[i] = lim ? 1 : 0;
                    if (!(lim && hold))
                        mc[i] = countUpDown ? (mc[i] + 1) % (MX[i] + 1) : (mc[i] + MX[i]) % (MX[i] + 1);
                end
            end else begin
                mtc[i] = 0;
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1 check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        repeat (n) cycle(tag);
    endtask

    initial begin
        model_reset();
        #3 check_all("reset");
        chk("reset.at_zero_const", int'(az0), 1);
        chk("reset.at_max_const", int'(am1), 0);
        @(negedge clk) rst = 1'b0;

        enable = 1'b1;
        countUpDown = 1'b1;
        run("up", 17);
        chk("up.end_count0", int'(cnt0), 1);

        countUpDown = 1'b0;
        run("down", 24);

        countUpDown = 1'b1;
        run("pre_up", 4);
        enable = 1'b0;
        run("pre_hold", 2);
        enable = 1'b1;
        run("pre_resume", 5);

        load = 1'b1;
        load_val = 4'd12;
        cycle("load12");
        chk("load12.clamp1", int'(cnt1), 9);
        chk("load12.pass0", int'(cnt0), 12);
        load = 1'b0;
        for (int k = 0; k < 3 && mp[1] != 2; k++) cycle("align");
        chk("align.phase", mp[1], 2);
        load = 1'b1;
        load_val = 4'd5;
        cycle("load_on_tick");
        chk("load_on_tick.count1", int'(cnt1), 5);
        chk("load_on_tick.tc1", int'(tc1), 0);
        load = 1'b0;

        run("pre_rst", 9);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst.count1_const", int'(cnt1), 0);
        @(negedge clk) rst = 1'b0;
        run("post_rst", 6);

`ifdef CNT_UPDN_SAT_EN
        sat = 1'b1;
        load = 1'b1;
        load_val = 4'd14;
        cycle("sat_load");
        load = 1'b0;
        countUpDown = 1'b1;
        run("sat_up", 8);
        chk("sat_up.hold0", int'(cnt0), 15);
        load = 1'b1;
        load_val = 4'd1;
        cycle("sat_load0");
        load = 1'b0;
        countUpDown = 1'b0;
        run("sat_down", 8);
        chk("sat_down.hold0", int'(cnt0), 0);
        sat = 1'b0;
`endif

        repeat (400) begin
            enable = ($urandom_range(0, 3) != 0);
            countUpDown = $urandom_range(0, 1) != 0;
            load = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
`ifdef CNT_UPDN_SAT_EN
            sat = $urandom_range(0, 1) != 0;
`endif
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
